// File: rtl/gpr_file_mp_pkg.sv
// Shared constants, types and helpers for the multi-ported GPR file.
// The address width and the busy-vector popcount are computed here.
package gpr_file_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;
    // Widest busy vector the popcount helper accepts.
    localparam int NREG_MAX   = 256;

    function automatic int addr_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            w = ((32'd1 << i) < n) ? i + 1 : w;
        end
        return w;
    endfunction

    typedef logic [addr_width(NREG_DEF)-1:0] reg_idx_t;

    function automatic logic [8:0] popcount(input logic [NREG_MAX-1:0] v);
        logic [8:0] cnt;
        cnt = 9'd0;
        for (int i = 0; i < NREG_MAX; i++) begin
            cnt = cnt + {8'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: stored data or same-cycle forwarded write data,
// plus the pending-producer flag for the addressed register.
module gpr_rd_port
    import gpr_file_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREG)
) (
    input  logic [AW-1:0]         raddr,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]     regs [NREG],
    input  logic [NREG-1:0]       busy,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rbusy
);

    logic              hit_s;
    logic              match_s;
    logic [DATA_W-1:0] fwd_s;

    // Forwarding mux: ascending port scan so the highest matching port wins
    always_comb begin
        hit_s   = 1'b0;
        match_s = 1'b0;
        fwd_s   = regs[raddr];
        for (int p = 0; p < NWR; p++) begin
            match_s = (BYPASS != 0) && we[p] && (waddr[p*AW +: AW] == raddr) && (raddr != '0);
            hit_s   = hit_s | match_s;
            fwd_s   = match_s ? wdata[p*DATA_W +: DATA_W] : fwd_s;
        end
        rdata = (raddr == '0) ? '0 : fwd_s;
        rbusy = (raddr == '0) ? 1'b0 : (busy[raddr] & ~hit_s);
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-ported general-purpose register file with a busy scoreboard.
// Register 0 is hard-wired to zero and is never marked busy.
module gpr_file_mp
    import gpr_file_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 3,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_v,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     busy_d;
    logic [NREG-1:0]     set_s;
    logic [NREG-1:0]     clr_s;
    logic [AW:0]         busy_cnt_q;
    logic [AW:0]         busy_cnt_d;
    logic [NREG_MAX-1:0] pop_in_s;

    // Next register contents; later ports overwrite earlier ones on a collision
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREG; r++) begin
            for (int p = 0; p < NWR; p++) begin
                regs_d[r] = (we[p] && (waddr[p*AW +: AW] == AW'(r))) ? wdata[p*DATA_W +: DATA_W] : regs_d[r];
            end
        end
        regs_d[0] = '0;
    end

    // Busy scoreboard: issue beats a same-cycle write-back; flush beats both
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int r = 1; r < NREG; r++) begin
            set_s[r] = iss_v && (iss_addr == AW'(r));
            for (int p = 0; p < NWR; p++) begin
                clr_s[r] = clr_s[r] | (we[p] && (waddr[p*AW +: AW] == AW'(r)));
            end
        end
        busy_d    = flush ? '0 : ((busy_q & ~clr_s) | set_s);
        busy_d[0] = 1'b0;
        pop_in_s  = '0;
        pop_in_s[NREG-1:0] = busy_d;
        busy_cnt_d = (AW+1)'(popcount(pop_in_s));
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        gpr_rd_port #(
            .DATA_W (DATA_W),
            .NREG   (NREG),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rd (
            .raddr (raddr[g*AW +: AW]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .regs  (regs_q),
            .busy  (busy_q),
            .rdata (rdata[g*DATA_W +: DATA_W]),
            .rbusy (rbusy[g])
        );
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: a cycle vector table plus hand sequences,
// with expectations queued at drive time and compared mid-cycle.
module tb_gpr_file_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  rbusy;
    logic        iss_v;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic [95:0] rdata_nb;
    logic [2:0]  rbusy_nb;
    logic [5:0]  busy_cnt_nb;

    gpr_file_mp #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_v(iss_v),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    gpr_file_mp #(.DATA_W(32), .NREG(32), .NRD(3), .NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb), .iss_v(iss_v),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic [2:0]  eb;
        logic [5:0]  ecnt;
    } vec_t;

    // kind: 0 rdata, 1 rbusy vector, 2 busy_cnt, 3 rdata of the no-bypass instance
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   tests_run;
    int   tests_failed;

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            0:       return rdata[port*32 +: 32];
            1:       return {29'd0, rbusy};
            2:       return {26'd0, busy_cnt};
            3:       return rdata_nb[port*32 +: 32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic expect_val(input string name, input int kind, input int port, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = actual(e.kind, e.port);
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = 2'b00;
        waddr    = 10'd0;
        wdata    = 64'd0;
        raddr    = 15'd0;
        iss_v    = 1'b0;
        iss_addr = 5'd0;
        flush    = 1'b0;
    endtask

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;

        //            we     wa0   wd0            wa1   wd1       ra0   ra1   ra2    iss   ia    fl     ed0       ed1       ed2       eb      cnt
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd1, 5'd5, 5'd31, 1'b0, 5'd0, 1'b0, 32'h0,    32'h0,    32'h0,    3'b000, 6'd0});
        vecs.push_back('{2'b01, 5'd0, 32'hDEADBEEF,  5'd0, 32'h0,    5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 1'b0, 32'h0,    32'h0,    32'h0,    3'b000, 6'd0});
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd0, 5'd0, 5'd0,  1'b1, 5'd0, 1'b0, 32'h0,    32'h0,    32'h0,    3'b000, 6'd0});
        vecs.push_back('{2'b11, 5'd7, 32'h11,        5'd7, 32'h22,   5'd7, 5'd7, 5'd0,  1'b0, 5'd0, 1'b0, 32'h22,   32'h22,   32'h0,    3'b000, 6'd0});
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd7, 5'd5, 5'd7,  1'b1, 5'd3, 1'b0, 32'h22,   32'h0,    32'h22,   3'b000, 6'd0});
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd3, 5'd3, 5'd7,  1'b0, 5'd0, 1'b0, 32'h0,    32'h0,    32'h22,   3'b011, 6'd1});
        vecs.push_back('{2'b10, 5'd0, 32'h0,         5'd3, 32'h55,   5'd3, 5'd1, 5'd3,  1'b0, 5'd0, 1'b0, 32'h55,   32'h0,    32'h55,   3'b000, 6'd1});
        vecs.push_back('{2'b01, 5'd4, 32'h44,        5'd0, 32'h0,    5'd3, 5'd4, 5'd4,  1'b1, 5'd4, 1'b0, 32'h55,   32'h44,   32'h44,   3'b000, 6'd0});
        vecs.push_back('{2'b10, 5'd0, 32'h0,         5'd5, 32'h66,   5'd4, 5'd4, 5'd4,  1'b1, 5'd5, 1'b0, 32'h44,   32'h44,   32'h44,   3'b111, 6'd1});
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd4, 5'd5, 5'd6,  1'b1, 5'd6, 1'b1, 32'h44,   32'h66,   32'h0,    3'b011, 6'd2});
        vecs.push_back('{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    5'd4, 5'd5, 5'd6,  1'b0, 5'd0, 1'b0, 32'h44,   32'h66,   32'h0,    3'b000, 6'd0});

        // Reset with a write and an issue pending: neither may survive
        idle();
        rst_n    = 1'b0;
        we       = 2'b01;
        waddr    = {5'd0, 5'd5};
        wdata    = {32'd0, 32'h12345678};
        iss_v    = 1'b1;
        iss_addr = 5'd6;
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < vecs.size(); i++) begin
            v        = vecs[i];
            we       = v.we;
            waddr    = {v.wa1, v.wa0};
            wdata    = {v.wd1, v.wd0};
            raddr    = {v.ra2, v.ra1, v.ra0};
            iss_v    = v.iss;
            iss_addr = v.ia;
            flush    = v.fl;
            expect_val($sformatf("v%0d_rdata0", i), 0, 0, v.ed0);
            expect_val($sformatf("v%0d_rdata1", i), 0, 1, v.ed1);
            expect_val($sformatf("v%0d_rdata2", i), 0, 2, v.ed2);
            expect_val($sformatf("v%0d_rbusy", i), 1, 0, {29'd0, v.eb});
            expect_val($sformatf("v%0d_busy_cnt", i), 2, 0, {26'd0, v.ecnt});
            #3;
            drain();
            tick();
        end

        // Reset while registers are busy clears busy state and data
        idle();
        iss_v    = 1'b1;
        iss_addr = 5'd10;
        tick();
        iss_addr = 5'd11;
        tick();
        idle();
        expect_val("pre_rst_busy_cnt", 2, 0, 32'd2);
        #3;
        drain();
        rst_n    = 1'b0;
        iss_v    = 1'b1;
        iss_addr = 5'd12;
        we       = 2'b01;
        waddr    = {5'd0, 5'd7};
        wdata    = {32'd0, 32'h77};
        tick();
        rst_n = 1'b1;
        idle();
        raddr = {5'd7, 5'd11, 5'd10};
        expect_val("post_rst_busy_cnt", 2, 0, 32'd0);
        expect_val("post_rst_rbusy", 1, 0, 32'd0);
        expect_val("post_rst_r10", 0, 0, 32'd0);
        expect_val("post_rst_r7", 0, 2, 32'd0);
        #3;
        drain();
        tick();

        // No-bypass instance returns the stored value during the write cycle
        idle();
        we    = 2'b01;
        waddr = {5'd0, 5'd9};
        wdata = {32'd0, 32'hA5};
        raddr = {5'd0, 5'd0, 5'd9};
        expect_val("nb_same_cycle_r9", 3, 0, 32'h0);
        expect_val("byp_same_cycle_r9", 0, 0, 32'hA5);
        #3;
        drain();
        tick();
        idle();
        raddr = {5'd0, 5'd0, 5'd9};
        expect_val("nb_next_cycle_r9", 3, 0, 32'hA5);
        #3;
        drain();
        tick();

        // Fill every issuable register: count tops out at NREG-1 and holds
        for (int r = 1; r < 32; r++) begin
            iss_v    = 1'b1;
            iss_addr = 5'(r);
            tick();
        end
        idle();
        expect_val("full_busy_cnt", 2, 0, 32'd31);
        expect_val("full_rbusy_r0", 1, 0, 32'd0);
        #3;
        drain();
        iss_v    = 1'b1;
        iss_addr = 5'd31;
        tick();
        idle();
        raddr = {5'd31, 5'd1, 5'd2};
        expect_val("reissue_busy_cnt", 2, 0, 32'd31);
        expect_val("full_rbusy", 1, 0, 32'd7);
        #3;
        drain();
        flush    = 1'b1;
        iss_v    = 1'b1;
        iss_addr = 5'd1;
        tick();
        idle();
        expect_val("flush_busy_cnt", 2, 0, 32'd0);
        #3;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
